// File: rtl/tge_rst_pkg.sv
// Shared types and register-map constants for the 10GbE reset/enable sequencer.
package tge_rst_pkg;

    typedef enum logic [1:0] {
        CORE_RST  = 2'd0,
        WAIT_LINK = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int RB_CORE_RST = 0;
    localparam int RB_CNT_CLR  = 1;
    localparam int RB_TX_EN    = 2;
    localparam int RB_TO_CLR   = 3;
    localparam int RB_BITS     = 4;

    localparam int ST_STATE_LSB   = 0;
    localparam int ST_TIMEOUT_BIT = 2;
    localparam int ST_RETRY_LSB   = 8;

    // Counter width that never collapses to zero bits for tiny terminal counts.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tge_rst_ctrl_stretch.sv
// rst_pulse_stretch: reloadable down-counter that turns a one-cycle edge into a
// WIDTH-cycle active pulse; a new edge while running restarts the full width.
module rst_pulse_stretch
    import tge_rst_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic trig,
    output logic active
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LOAD = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (trig) begin
            cnt    <= LOAD;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tge_rst_ctrl.sv
// Reset/enable sequencer for the 10GbE core driven by the software rst register.
// Optional status readback word is built only when TGE_RST_STATUS_EN is defined.
module tge_rst_ctrl
    import tge_rst_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int CLR_CYCLES   = 4,
    parameter int LINK_TIMEOUT = 1000000
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] user_data_in,
    input  logic        link_up,
    output logic        tge_rst,
    output logic        cnt_rst,
    output logic        tx_en,
    output logic        rst_busy,
    output logic        link_timeout
`ifdef TGE_RST_STATUS_EN
    ,
    output logic [31:0] status_out
`endif
);

    localparam int             RCW      = cnt_w(RST_CYCLES);
    localparam int             TCW      = cnt_w(LINK_TIMEOUT);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(LINK_TIMEOUT - 1);

    logic [RB_BITS-1:0] d_q, d_p;
    logic               rst_edge, clr_edge, to_edge;
    logic               unused_bits;

    state_t         state, state_nx;
    logic [RCW-1:0] rcnt, rcnt_nx;
    logic [TCW-1:0] timer, timer_nx;
    logic           timeout, lt_nx;
    logic           clr_active;

    assign unused_bits = ^user_data_in[31:RB_BITS];

    // Two-flop input path; edges are registered so outputs land three cycles after a write.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            d_q      <= '0;
            d_p      <= '0;
            rst_edge <= 1'b0;
            clr_edge <= 1'b0;
            to_edge  <= 1'b0;
        end else begin
            d_q      <= user_data_in[RB_BITS-1:0];
            d_p      <= d_q;
            rst_edge <= d_q[RB_CORE_RST] & ~d_p[RB_CORE_RST];
            clr_edge <= d_q[RB_CNT_CLR]  & ~d_p[RB_CNT_CLR];
            to_edge  <= d_q[RB_TO_CLR]   & ~d_p[RB_TO_CLR];
        end
    end

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        timer_nx = timer;
        timeout  = 1'b0;
        case (state)
            CORE_RST: begin
                if (rcnt == RST_LAST) begin
                    state_nx = WAIT_LINK;
                    timer_nx = '0;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
            end
            WAIT_LINK: begin
                if (link_up) begin
                    state_nx = RUN;
                end else if (timer == TO_LAST) begin
                    timeout  = 1'b1;
                    state_nx = CORE_RST;
                    rcnt_nx  = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            RUN: begin
                if (!link_up) begin
                    state_nx = WAIT_LINK;
                    timer_nx = '0;
                end
            end
            default: begin
                state_nx = CORE_RST;
                rcnt_nx  = '0;
            end
        endcase
        // A software core reset restarts the whole sequence from any state.
        if (rst_edge) begin
            state_nx = CORE_RST;
            rcnt_nx  = '0;
        end
        lt_nx = timeout | (link_timeout & ~to_edge);
    end

    // Outputs are registered from next-state so they stay aligned with the state register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= CORE_RST;
            rcnt         <= '0;
            timer        <= '0;
            tge_rst      <= 1'b1;
            rst_busy     <= 1'b1;
            tx_en        <= 1'b0;
            link_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            rcnt         <= rcnt_nx;
            timer        <= timer_nx;
            tge_rst      <= (state_nx == CORE_RST);
            rst_busy     <= (state_nx != RUN);
            tx_en        <= (state_nx == RUN) & d_p[RB_TX_EN];
            link_timeout <= lt_nx;
        end
    end

    rst_pulse_stretch #(
        .WIDTH(CLR_CYCLES)
    ) u_clr_stretch (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .trig      (clr_edge),
        .active    (clr_active)
    );

    assign cnt_rst = clr_active | tge_rst;

`ifdef TGE_RST_STATUS_EN
    logic [7:0] retry, retry_base, retry_nx;

    always_comb begin
        retry_base = to_edge ? 8'h00 : retry;
        retry_nx   = retry_base;
        if (timeout && (retry_base != 8'hFF)) begin
            retry_nx = retry_base + 8'h01;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            retry      <= '0;
            status_out <= '0;
        end else begin
            retry      <= retry_nx;
            status_out <= '0;
            status_out[ST_STATE_LSB +: 2] <= state_nx;
            status_out[ST_TIMEOUT_BIT]    <= lt_nx;
            status_out[ST_RETRY_LSB +: 8] <= retry_nx;
        end
    end
`endif

endmodule

// File: tb/tb_tge_rst_ctrl.sv
// Directed bench for tge_rst_ctrl: boot sequence, counter-clear stretch, link loss,
// watchdog retry and flag clearing, mid-reset restart and asynchronous reset.
module tb_tge_rst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        link_up;
    logic        tge_rst, cnt_rst, tx_en, rst_busy, link_timeout;
`ifdef TGE_RST_STATUS_EN
    logic [31:0] status_out;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0, k, w, n;

    always #5 clk = ~clk;

    tge_rst_ctrl #(
        .RST_CYCLES  (16),
        .CLR_CYCLES  (4),
        .LINK_TIMEOUT(100)
    ) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .user_data_in(data),
        .link_up     (link_up),
        .tge_rst     (tge_rst),
        .cnt_rst     (cnt_rst),
        .tx_en       (tx_en),
        .rst_busy    (rst_busy),
        .link_timeout(link_timeout)
`ifdef TGE_RST_STATUS_EN
        ,
        .status_out  (status_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic nc();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) nc();
    endtask

    initial begin
        rst_n   = 1'b0;
        data    = 32'h0;
        link_up = 1'b1;
        nc();
        nc();
        check("rst_tge_rst", tge_rst, 1);
        check("rst_cnt_rst", cnt_rst, 1);
        check("rst_tx_en", tx_en, 0);
        check("rst_busy", rst_busy, 1);
        check("rst_link_timeout", link_timeout, 0);
`ifdef TGE_RST_STATUS_EN
        check("rst_status", status_out, 32'h0);
`endif

        // Boot: reset stretch, then RUN one cycle after leaving CORE_RST.
        rst_n = 1'b1;
        check("boot_cnt_rst", cnt_rst, 1);
        n = 0;
        while (tge_rst === 1'b1 && n < 64) begin
            n++;
            nc();
        end
        check("boot_tge_rst_len", n, 16);
        check("boot_wait_busy", rst_busy, 1);
        check("boot_wait_cnt_rst", cnt_rst, 0);
        nc();
        check("boot_run_busy", rst_busy, 0);
        check("boot_run_tx_en", tx_en, 0);
`ifdef TGE_RST_STATUS_EN
        check("boot_status", status_out, 32'h2);
`endif
        k = cyc;
        data = 32'h4;
        wait_until(k + 2);
        check("txen_early", tx_en, 0);
        wait_until(k + 3);
        check("txen_on", tx_en, 1);

        // Single counter-clear pulse.
        k = cyc;
        data = 32'hFFFF_FFF6;
        nc();
        data = 32'h4;
        wait_until(k + 2);
        check("clr_before", cnt_rst, 0);
        nc();
        n = 0;
        while (cnt_rst === 1'b1 && n < 32) begin
            n++;
            nc();
        end
        check("clr_len", n, 4);

        // Re-trigger two cycles later extends the pulse.
        wait_until(cyc + 2);
        k = cyc;
        data = 32'h6;
        wait_until(k + 1);
        data = 32'h4;
        wait_until(k + 3);
        data = 32'h6;
        wait_until(k + 4);
        data = 32'h4;
        wait_until(k + 6);
        check("retrig_mid", cnt_rst, 1);
        wait_until(k + 9);
        check("retrig_last", cnt_rst, 1);
        wait_until(k + 10);
        check("retrig_end", cnt_rst, 0);

        // Link loss for five cycles while transmitting.
        k = cyc;
        link_up = 1'b0;
        wait_until(k + 1);
        check("linkdrop_tx_en", tx_en, 0);
        check("linkdrop_busy", rst_busy, 1);
        wait_until(k + 5);
        check("linkdrop_hold", tx_en, 0);
        link_up = 1'b1;
        wait_until(k + 6);
        check("linkback_tx_en", tx_en, 1);
        check("linkback_busy", rst_busy, 0);

        // Watchdog retry, flag clear, and clear colliding with a timeout.
        wait_until(cyc + 2);
        k = cyc;
        link_up = 1'b0;
        wait_until(k + 100);
        check("to_before_rst", tge_rst, 0);
        check("to_before_flag", link_timeout, 0);
        wait_until(k + 101);
        check("to_rst", tge_rst, 1);
        check("to_flag", link_timeout, 1);
        wait_until(k + 105);
        data = 32'hC;
        wait_until(k + 106);
        data = 32'h4;
        wait_until(k + 110);
        check("to_cleared", link_timeout, 0);
        wait_until(k + 214);
        data = 32'hC;
        wait_until(k + 215);
        data = 32'h4;
        wait_until(k + 216);
        check("to2_before", link_timeout, 0);
        wait_until(k + 217);
        check("to2_set_wins", link_timeout, 1);
        check("to2_rst", tge_rst, 1);

        // Software reset at count 10 of CORE_RST restarts the full hold.
        w = k + 224;
        wait_until(w);
        data = 32'h5;
        link_up = 1'b1;
        wait_until(w + 9);
        check("restart_extends", tge_rst, 1);
        wait_until(w + 18);
        check("restart_last", tge_rst, 1);
        wait_until(w + 19);
        check("restart_done", tge_rst, 0);
        wait_until(w + 20);
        check("restart_run_busy", rst_busy, 0);
        check("restart_run_tx_en", tx_en, 1);
`ifdef TGE_RST_STATUS_EN
        check("restart_status", status_out, 32'h0000_0106);
`endif

        // Asynchronous reset in WAIT_LINK.
        wait_until(w + 21);
        link_up = 1'b0;
        wait_until(w + 22);
        check("pre_arst_busy", rst_busy, 1);
        check("pre_arst_cnt_rst", cnt_rst, 0);
        check("pre_arst_flag", link_timeout, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tge_rst", tge_rst, 1);
        check("arst_cnt_rst", cnt_rst, 1);
        check("arst_tx_en", tx_en, 0);
        check("arst_busy", rst_busy, 1);
        check("arst_flag", link_timeout, 0);
`ifdef TGE_RST_STATUS_EN
        check("arst_retry", status_out[15:8], 32'h0);
`endif
        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
